opsg_cmd_writer: RTL and testbench
==================================

// Module: opsg_cmd_writer
// PURPOSE
//  Host-side bus master for the opsg write port. Accepts register-update requests
//  (register select + value) on a valid/ready handshake and buffers them in a FIFO.
//  Serialises each request into the PSG byte protocol (latch byte, plus a data byte
//  for tone registers) and drives n_wr/data with programmable strobe timing.
//  Sits between the sound-driver sequencer and the opsg core.
// PARAMETERS
//  TONE_WIDTH  10  tone period width; must be 10 (4 bits in latch byte + 6 in data byte)
//  WR_PULSE    2   cycles n_wr is held low per byte; must be >= 1
//  WR_GAP      4   cycles n_wr is held high after each strobe; must be >= 1
//  FIFO_DEPTH  4   request FIFO entries; power of 2, >= 2
// PORTS
//  clk          in   1            system clock, same clock as the opsg core
//  n_rst        in   1            reset, asynchronous, active-low
//  req_valid    in   1            request present
//  req_ready    out  1            FIFO can accept (= !full)
//  req_reg      in   3            register: 0 tone1,1 vol1,2 tone2,3 vol2,4 tone3,5 vol3,6 noise ctrl,7 vol4
//  req_value    in   TONE_WIDTH   value; tone uses [9:0], vol uses [3:0], ctrl uses [2:0]
//  n_wr         out  1            write strobe to opsg, active-low
//  data         out  8            byte to opsg
//  busy         out  1            FIFO non-empty or FSM not IDLE
//  fifo_count   out  clog2(D)+1   current FIFO occupancy
// BEHAVIOUR
//  Reset (async): n_wr=1, data=8'h00, FIFO empty, fifo_count=0, busy=0, FSM=IDLE.
//  req_ready=1 from the first clock after reset release. Reset asserted mid-strobe
//  forces n_wr high immediately; pending requests are discarded.
//  Handshake: a push occurs on a posedge with req_valid && req_ready; {req_reg,req_value} stored.
//  req_ready is combinational from full only; never depends on req_valid.
//  Push while full is impossible (ready=0); push and pop in the same cycle are both
//  legal when not full, and occupancy is unchanged.
//  Encoding:
//   latch byte = {1'b1, req_reg, v[3:0]}; for reg 6: {1'b1,3'b110,1'b0,v[2:0]}.
//   data byte (reg 0/2/4 only) = {2'b00, v[9:4]}. Volume/ctrl registers send the latch byte only.
//   Unused value bits are ignored.
//  FSM: IDLE, SETUP, STROBE, HOLD.
//   IDLE: if FIFO non-empty, pop and go to SETUP. data=latch byte, n_wr=1.
//   SETUP (1 cycle): data stable, n_wr=1 -> STROBE.
//   STROBE (WR_PULSE cycles): n_wr=0, data stable -> HOLD.
//   HOLD (WR_GAP cycles): n_wr=1, data stable.
//    If a data byte is pending: load it, then go to SETUP.
//    Else if FIFO non-empty: pop, then go to SETUP with the new latch byte (no IDLE cycle).
//    Else: go to IDLE.
//  data changes only on the cycle entering SETUP; never while n_wr=0.
//  Timing: push at edge T into an empty idle block -> SETUP at T+1.
//  n_wr low for cycles T+2..T+1+WR_PULSE. Each byte costs 1+WR_PULSE+WR_GAP cycles.
//  Ordering: strict FIFO order. The two bytes of a tone write are never interleaved
//  with another request.
//  FIFO pointers wrap modulo FIFO_DEPTH; occupancy is tracked by count, so full and
//  empty are unambiguous.
//  busy=1 from the cycle after a push until the FSM returns to IDLE with the FIFO empty.
// TESTING
//  Reset: hold n_rst=0 -> n_wr=1, data=00, busy=0, req_ready=0 in reset.
//   Release -> req_ready=1, no strobes issued.
//  Tone: push reg=0, value=10'h3FE at T -> data=8'h8E with n_wr low T+2..T+3,
//   then data=8'h3F with n_wr low T+9..T+10 (defaults); busy=0 at T+15.
//  Volume/ctrl: push reg=5 val=5 -> one strobe, data=8'hD5.
//   Push reg=6 val=10'h3FC -> data=8'hE4. Push reg=1 val=10'h3F5 -> data=8'h95.
//  Backpressure: hold req_valid for 8 back-to-back vol4 requests (vals 0..7), DEPTH=4.
//   -> req_ready drops once fifo_count=4; bytes F0..F7 are emitted in order, none lost or duplicated.
//  Protocol monitor, all tests: data is never seen changing while n_wr=0; every
//   n_wr low pulse lasts exactly WR_PULSE; high gaps are >= WR_GAP+1 between bytes.
//  Reset mid-operation: assert n_rst during STROBE of a tone write with 2 queued
//   -> n_wr=1 at once, fifo_count=0; after release, no stray bytes are emitted.

Source files
------------

// File: rtl/opsg_cmd_writer.sv
// Host-side write master for the opsg core: buffers register-update requests in a FIFO
// and serialises each into PSG latch/data bytes with programmable n_wr strobe timing.
module opsg_cmd_writer #(
  parameter int TONE_WIDTH = 10,
  parameter int WR_PULSE   = 2,
  parameter int WR_GAP     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [2:0]                    req_reg,
  input  logic [TONE_WIDTH-1:0]         req_value,
  output logic                          n_wr,
  output logic [7:0]                    data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int EW      = 3 + TONE_WIDTH;
  localparam int CNT_MAX = (WR_PULSE > WR_GAP) ? WR_PULSE : WR_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PULSE_LOAD = CW'(WR_PULSE - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(WR_GAP - 1);
  localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  // ---------------- request FIFO ----------------
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ready_en_q;
  logic          full, empty, push, pop;
  logic [EW-1:0] head;
  logic [2:0]    head_reg;
  logic [TONE_WIDTH-1:0] head_val;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign req_ready = ready_en_q && !full;
  assign push      = req_valid && req_ready;
  assign head      = mem_q[rd_ptr_q];
  assign head_reg  = head[EW-1 -: 3];
  assign head_val  = head[TONE_WIDTH-1:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_en_q <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_reg, req_value};
  end

  // ---------------- byte encoding ----------------
  function automatic logic [7:0] latch_byte(input logic [2:0] r, input logic [TONE_WIDTH-1:0] v);
    if (r == 3'd6) return {1'b1, 3'b110, 1'b0, v[2:0]};
    else           return {1'b1, r, v[3:0]};
  endfunction

  function automatic logic is_tone(input logic [2:0] r);
    return !r[0] && (r != 3'd6);
  endfunction

  function automatic logic [7:0] data_byte(input logic [TONE_WIDTH-1:0] v);
    return {2'b00, v[9:4]};
  endfunction

  // ---------------- strobe FSM ----------------
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    pend_byte_q, pend_byte_d;
  logic          pend_q, pend_d;
  logic          n_wr_q, n_wr_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    pend_d      = pend_q;
    pend_byte_d = pend_byte_q;
    n_wr_d      = 1'b1;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          data_d      = latch_byte(head_reg, head_val);
          pend_d      = is_tone(head_reg);
          pend_byte_d = data_byte(head_val);
          state_d     = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = PULSE_LOAD;
        n_wr_d  = 1'b0;
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          n_wr_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (pend_q) begin
          // Second byte of a tone write goes out before any further pop.
          data_d  = pend_byte_q;
          pend_d  = 1'b0;
          state_d = S_SETUP;
        end else if (!empty) begin
          pop         = 1'b1;
          data_d      = latch_byte(head_reg, head_val);
          pend_d      = is_tone(head_reg);
          pend_byte_d = data_byte(head_val);
          state_d     = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      data_q      <= 8'h00;
      pend_q      <= 1'b0;
      pend_byte_q <= 8'h00;
      n_wr_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      pend_q      <= pend_d;
      pend_byte_q <= pend_byte_d;
      n_wr_q      <= n_wr_d;
    end
  end

  assign n_wr       = n_wr_q;
  assign data       = data_q;
  assign busy       = !empty || (state_q != S_IDLE);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_opsg_cmd_writer.sv
// Scoreboard bench for opsg_cmd_writer: stimulus queues expected bytes, a monitor
// pops them on each n_wr falling edge and also polices strobe width, gap and data stability.
module tb_opsg_cmd_writer;

  localparam int WR_PULSE = 2;
  localparam int WR_GAP   = 4;
  localparam int DEPTH    = 4;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_reg = '0;
  logic [9:0] req_value = '0;
  logic       n_wr;
  logic [7:0] data;
  logic       busy;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  opsg_cmd_writer #(
    .TONE_WIDTH(10),
    .WR_PULSE(WR_PULSE),
    .WR_GAP(WR_GAP),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_reg(req_reg),
    .req_value(req_value),
    .n_wr(n_wr),
    .data(data),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  int errors = 0;
  int checks = 0;
  int strobes = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  logic       prev_nwr = 1'b1;
  logic [7:0] prev_data = '0;
  int         lo_cnt = 0;
  int         hi_cnt = 0;
  bit         have_rise = 0;
  bit         data_moved = 0;

  always @(negedge clk) begin
    if (!n_rst) begin
      prev_nwr   = 1'b1;
      lo_cnt     = 0;
      hi_cnt     = 0;
      have_rise  = 0;
      data_moved = 0;
      exp_q.delete();
    end else begin
      if (!n_wr) begin
        if (prev_nwr) begin
          strobes++;
          if (have_rise) check("gap>=WR_GAP+1", 32'(hi_cnt >= WR_GAP + 1), 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected strobe: data %0h, none expected", data);
          end else begin
            check("strobe byte", data, exp_q.pop_front());
          end
          lo_cnt     = 1;
          data_moved = 0;
        end else begin
          lo_cnt++;
          if (data !== prev_data) data_moved = 1;
        end
      end else begin
        if (!prev_nwr) begin
          check("pulse width", lo_cnt, WR_PULSE);
          check("data stable while low", data_moved, 0);
          hi_cnt    = 1;
          have_rise = 1;
        end else begin
          hi_cnt++;
        end
      end
      prev_nwr  = n_wr;
      prev_data = data;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready wait timeout", req_ready, 1);
  endtask

  task automatic push(input logic [2:0] r, input logic [9:0] v);
    wait_ready();
    req_valid = 1'b1;
    req_reg   = r;
    req_value = v;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle timeout", busy, 0);
  endtask

  initial begin
    int s0;
    bit saw_full;
    int budget;

    // reset state
    repeat (3) @(negedge clk);
    check("rst n_wr", n_wr, 1);
    check("rst data", data, 8'h00);
    check("rst busy", busy, 0);
    check("rst req_ready", req_ready, 0);
    check("rst fifo_count", fifo_count, 0);
    n_rst = 1'b1;
    @(negedge clk);
    check("ready after release", req_ready, 1);
    repeat (4) @(negedge clk);
    check("no strobes after release", strobes, 0);

    // tone write timing: push lands at edge T
    exp_q.push_back(8'h8E);
    exp_q.push_back(8'h3F);
    req_valid = 1'b1;
    req_reg   = 3'd0;
    req_value = 10'h3FE;
    @(negedge clk);
    req_valid = 1'b0;
    check("tone count@T", fifo_count, 1);
    check("tone busy@T", busy, 1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("tone n_wr@T+%0d", k), n_wr,
            (k == 2 || k == 3 || k == 9 || k == 10) ? 0 : 1);
      if (k == 2)  check("tone latch data", data, 8'h8E);
      if (k == 9)  check("tone data byte", data, 8'h3F);
      if (k == 14) check("busy@T+14", busy, 1);
      if (k == 15) check("busy@T+15", busy, 0);
    end

    // single-byte registers
    exp_q.push_back(8'hD5);
    push(3'd5, 10'h005);
    wait_idle();
    exp_q.push_back(8'hE4);
    push(3'd6, 10'h3FC);
    wait_idle();
    exp_q.push_back(8'h95);
    push(3'd1, 10'h3F5);
    wait_idle();
    check("queue drained singles", exp_q.size(), 0);

    // backpressure: 8 back-to-back vol4 writes with req_valid held
    saw_full  = 0;
    req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_reg   = 3'd7;
      req_value = 10'(k);
      budget    = 0;
      while (!req_ready && budget < 200) begin
        if (fifo_count == 3'd4) saw_full = 1;
        @(negedge clk);
        budget++;
      end
      check("bp ready timeout", req_ready, 1);
      exp_q.push_back(8'hF0 | 8'(k));
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("bp ready dropped at full", saw_full, 1);
    wait_idle();
    check("bp queue drained", exp_q.size(), 0);
    check("bp count empty", fifo_count, 0);

    // reset during the first strobe of a tone write with two queued behind it
    exp_q.push_back(8'h8E);
    exp_q.push_back(8'h3F);
    exp_q.push_back(8'h91);
    exp_q.push_back(8'hB2);
    push(3'd0, 10'h3FE);
    push(3'd1, 10'h001);
    push(3'd3, 10'h002);
    budget = 0;
    while (n_wr && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("mid strobe reached", n_wr, 0);
    check("two queued", fifo_count, 2);
    #2;
    n_rst = 1'b0;
    exp_q.delete();
    #1;
    check("mid rst n_wr", n_wr, 1);
    check("mid rst count", fifo_count, 0);
    check("mid rst busy", busy, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    s0 = strobes;
    repeat (30) @(negedge clk);
    check("no stray strobes", strobes, s0);
    check("post rst count", fifo_count, 0);

    // block still works afterwards
    exp_q.push_back(8'hB9);
    push(3'd3, 10'h009);
    wait_idle();
    repeat (2) @(negedge clk);
    check("final queue drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
